cordic_seq: RTL and testbench
=============================

Name: cordic_seq

Overview:
Iterative CORDIC sine/cosine unit with a Nios II multicycle custom-instruction handshake.
- One shared shift-add stage is reused for 16 iterations, sequenced by an FSM and an iteration counter.
- This trades the fully unrolled combinational chain for 17-cycle latency and a small area.
- Sits on the Nios II custom-instruction port beside the other trig accelerators. Software selects cos, sin or residual angle via n.

Parameters:
- ITER, 16, number of CORDIC iterations (counter width = clog2(ITER+1)).
- W, 32, datapath width; all values signed Q2.30 (radians for angles).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  Nios clock enable; when low, all state holds
- start  in  1  one-cycle request; dataa and n are valid in the same cycle
- n  in  2  function: 0=cos, 1=sin, 2=residual z, 3=reserved
- dataa  in  W  input angle, signed Q2.30, valid range |dataa| <= 0x6487ED51 (pi/2)
- done  out  1  one-cycle pulse; result valid in the same cycle
- busy  out  1  high from the start-accept edge until done has been emitted
- result  out  W  registered result, signed Q2.30

Behaviour:
- Reset (async, reset_n low): state=IDLE, cnt=0, x=y=z=0, fn=0, result=0, done=0, busy=0.
  - Reset taking effect mid-RUN aborts the operation silently; no done is emitted.
- An edge with clk_en=0 is a no-op: FSM, counter, x/y/z and result hold. A done already high stays high until the next enabled edge.
- FSM states IDLE, RUN, DONE.
  - IDLE: on an enabled edge with start=1, load x=K=0x26DD3B6A, y=0, z=dataa, fn=n, cnt=0, then go to RUN.
  - RUN: each enabled edge applies iteration i=cnt (see Iteration), cnt+=1. The edge where cnt==ITER-1 performs the last iteration and goes to DONE.
  - DONE: result is registered on the transition into DONE. result = x for fn 0, y for fn 1, z for fn 2, 0 for fn 3.
    - done=1 and busy=0 while in DONE; the next enabled edge returns to IDLE.
    - start=1 in the DONE cycle is accepted, as in IDLE (back-to-back operation, no bubble).
- Iteration i, with d = z[31] (sign):
  - d=0: x-=y>>>i; y+=x>>>i; z-=ATAN[i].
  - d=1: x+=y>>>i; y-=x>>>i; z+=ATAN[i].
  - The x and y updates both use the pre-iteration values.
  - >>> is a true arithmetic right shift on W bits; do not zero-fill or extend.
  - Wrap-around (mod 2^W) two's-complement add/sub, no saturation.
- Latency: start sampled at enabled edge T, iterations at edges T+1..T+16, done high in the cycle after edge T+16. This is 17 enabled cycles; stalled cycles extend it 1:1.
- start while busy (RUN) is ignored; operands are not re-latched.
- dataa outside ±pi/2 still runs to completion; the result is unspecified but done must still pulse.
- result holds its last value in IDLE. done is never asserted for more than one enabled cycle.

Decomposition:
- Package cordic_pkg holds:
  - the ITER default;
  - K_INIT = 32'h26DD3B6A;
  - ATAN table as a constant array (Q2.30), with entries 0..3 = 3243F6A9, 1DAC6705, 0FADBAFD, 07F56EA7;
  - state enum IDLE/RUN/DONE;
  - function codes FN_COS=0, FN_SIN=1, FN_RES=2.
- Sub-module cordic_stage: purely combinational, one iteration. Inputs x, y, z, shift amount i, atan_i; outputs x', y', z'.
- cordic_seq instantiates one cordic_stage and owns the FSM, counter and registers.

Test Plan:
- Reset mid-RUN: start with dataa=0x3243F6A9, pull reset_n low after 5 cycles, release -> done never pulses, busy=0, result=0, and the next start behaves normally.
- dataa=0, n=0 -> done exactly 17 cycles after start, result = 0x40000000 ±0x8000; busy high for cycles 1..16.
- dataa=0x3243F6A9 (pi/4), n=1 -> result 0x2D413CCD ±0x8000; same value with n=0.
- dataa=0xBCFAB720 (-pi/3), n=0 -> 0x20000000 ±0x8000; n=1 -> 0xC8930A2A ±0x8000 (-sqrt3/2); n=2 -> |result| < 0x10000.
- Stall: clk_en low for 3 random cycles mid-RUN -> done at 17+3 cycles with a bit-identical result to the unstalled run; done held through a clk_en-low cycle lasts one enabled cycle.
- Back-to-back: start with pi/6, n=1 (expect 0x20000000); start again in the DONE cycle with 0, n=0 -> second done 17 cycles later with 0x40000000. A start pulse mid-RUN is ignored and the first result is unaffected.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC sine/cosine unit.
//   ITER_DEF : default number of CORDIC iterations
//   K_INIT   : 1/gain for 16 iterations, Q2.30, preloaded into x
//   ATAN     : atan(2^-i) table, Q2.30 radians
//   state_t  : sequencer states
//   FN_*     : function codes selected by the custom-instruction n field
package cordic_pkg;

    localparam int ITER_DEF = 16;

    localparam logic [31:0] K_INIT = 32'h26DD3B6A;

    localparam logic [31:0] ATAN [0:15] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FN_COS = 2'd0;
    localparam logic [1:0] FN_SIN = 2'd1;
    localparam logic [1:0] FN_RES = 2'd2;

    // Beyond the stored table atan(2^-i) equals 2^-i to well below one LSB,
    // so larger iteration counts fall back to a plain power of two.
    function automatic logic [31:0] atan_lut(input int unsigned i);
        if (i < 16)
            return ATAN[i[3:0]];
        else if (i <= 30)
            return 32'd1 << (30 - i);
        else
            return '0;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC rotation-mode iteration, purely combinational.
//   x, y, z          : current vector and residual angle (signed Q2.30)
//   shift            : iteration index i, used as the arithmetic shift amount
//   atan_i           : atan(2^-i) for this iteration
//   x_next/y_next/z_next : values after the micro-rotation
module cordic_stage #(
    parameter int W  = 32,
    parameter int SW = 5
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [W-1:0]  z,
    input  logic        [SW-1:0] shift,
    input  logic signed [W-1:0]  atan_i,
    output logic signed [W-1:0]  x_next,
    output logic signed [W-1:0]  y_next,
    output logic signed [W-1:0]  z_next
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;

    // Both shifts read the pre-iteration x and y so the rotation is exact.
    assign x_sh = x >>> shift;
    assign y_sh = y >>> shift;

    // Rotate toward z = 0: a negative residual means we overshot.
    always_comb begin
        if (z[W-1]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan_i;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan_i;
        end
    end

endmodule

// File: rtl/cordic_seq.sv
// Iterative CORDIC sin/cos unit on a Nios II multicycle custom-instruction port.
// One shared cordic_stage is reused for ITER iterations.
//   clk, reset_n : clock, asynchronous active-low reset
//   clk_en       : clock enable; all state holds while low
//   start        : one-cycle request, dataa and n sampled with it
//   n            : 0=cos, 1=sin, 2=residual angle, 3=reserved (returns 0)
//   dataa        : input angle, signed Q2.30 radians
//   done         : high for the single enabled cycle the result is valid
//   busy         : high while iterating
//   result       : registered result, signed Q2.30
module cordic_seq
    import cordic_pkg::*;
#(
    parameter int ITER = ITER_DEF,
    parameter int W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_en,
    input  logic                start,
    input  logic        [1:0]   n,
    input  logic signed [W-1:0] dataa,
    output logic                done,
    output logic                busy,
    output logic signed [W-1:0] result
);

    localparam int CW = $clog2(ITER + 1);

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       cnt;
    logic [1:0]          fn;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    logic signed [W-1:0] x_n;
    logic signed [W-1:0] y_n;
    logic signed [W-1:0] z_n;
    logic signed [W-1:0] atan_i;
    logic                load;
    logic                last;

    function automatic logic signed [W-1:0] select_result(
        input logic [1:0]          f,
        input logic signed [W-1:0] xv,
        input logic signed [W-1:0] yv,
        input logic signed [W-1:0] zv
    );
        case (f)
            FN_COS:  return xv;
            FN_SIN:  return yv;
            FN_RES:  return zv;
            default: return '0;
        endcase
    endfunction

    assign atan_i = W'(atan_lut(32'(cnt)));
    assign last   = (cnt == CW'(ITER - 1));

    cordic_stage #(
        .W  (W),
        .SW (CW)
    ) u_stage (
        .x      (x),
        .y      (y),
        .z      (z),
        .shift  (cnt),
        .atan_i (atan_i),
        .x_next (x_n),
        .y_next (y_n),
        .z_next (z_n)
    );

    // done/busy decode straight from the state register, so they stay
    // glitch-free and hold naturally across clk_en-low cycles.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last)
                    state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                // Accepting here gives back-to-back operation with no bubble.
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            fn     <= FN_COS;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            result <= '0;
        end else if (clk_en) begin
            state <= state_next;
            if (load) begin
                x   <= W'(K_INIT);
                y   <= '0;
                z   <= dataa;
                fn  <= n;
                cnt <= '0;
            end else if (state == RUN) begin
                x   <= x_n;
                y   <= y_n;
                z   <= z_n;
                cnt <= cnt + CW'(1);
                // Capture from the stage outputs so the final iteration is
                // included in the same edge that enters DONE.
                if (last)
                    result <= select_result(fn, x_n, y_n, z_n);
            end
        end
    end

endmodule

// File: tb/tb_cordic_seq.sv
module tb_cordic_seq;

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic        done;
    logic        busy;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] PI4  = 32'h3243F6A9;
    localparam logic [31:0] PI6  = 32'h2182A46C;
    localparam logic [31:0] MPI3 = 32'hBCFAB720;

    cordic_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .n       (n),
        .dataa   (dataa),
        .done    (done),
        .busy    (busy),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  fn;
        logic [31:0] exp;
        int          tol;
        string       name;
    } vec_t;

    task automatic chk(input string name, input bit pass,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!pass) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit near(input logic [31:0] act, input logic [31:0] exp, input int tol);
        int d;
        d = int'(act - exp);
        if (d < 0) d = -d;
        return d <= tol;
    endfunction

    // Issue one operation. Inputs change on negedges; outputs are sampled on
    // negedges. cyc counts enabled-or-stalled cycles from the accept edge until
    // done is seen, bcnt counts cycles with busy high before done.
    task automatic do_op(input logic [31:0] a, input logic [1:0] fn,
                         input int stall_at, input int stall_len,
                         output logic [31:0] res, output int cyc,
                         output int bcnt, output bit ok);
        @(negedge clk);
        start = 1'b1; dataa = a; n = fn; clk_en = 1'b1;
        @(negedge clk);
        start = 1'b0; dataa = 32'h0; n = 2'd0;
        cyc = 1; bcnt = 0; ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcnt++;
            clk_en = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge clk);
            cyc++;
        end
        clk_en = 1'b1;
        res = result;
    endtask

    vec_t        vecs[$];
    logic [31:0] res, res_ref;
    int          cyc, bcnt, hits, sat;
    bit          ok;

    initial begin
        vecs.push_back('{32'h0, 2'd0, 32'h40000000, 32'h8000, "cos0"});
        vecs.push_back('{32'h0, 2'd1, 32'h00000000, 32'h8000, "sin0"});
        vecs.push_back('{PI4,   2'd1, 32'h2D413CCD, 32'h8000, "sin_pi4"});
        vecs.push_back('{PI4,   2'd0, 32'h2D413CCD, 32'h8000, "cos_pi4"});
        vecs.push_back('{MPI3,  2'd0, 32'h20000000, 32'h8000, "cos_mpi3"});
        vecs.push_back('{MPI3,  2'd3, 32'h00000000, 0,        "reserved"});
        vecs.push_back('{MPI3,  2'd1, 32'hC8930A2A, 32'h8000, "sin_mpi3"});
        vecs.push_back('{MPI3,  2'd2, 32'h00000000, 32'hFFFF, "res_mpi3"});
        vecs.push_back('{PI6,   2'd1, 32'h20000000, 32'h8000, "sin_pi6"});
        vecs.push_back('{PI6,   2'd0, 32'h376CF5D1, 32'h8000, "cos_pi6"});

        reset_n = 1'b0; clk_en = 1'b1; start = 1'b0; n = 2'd0; dataa = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_done",   done == 1'b0, 32'(done), 32'h0);
        chk("reset_busy",   busy == 1'b0, 32'(busy), 32'h0);
        chk("reset_result", result == 32'h0, result, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].fn, 1000, 0, res, cyc, bcnt, ok);
            chk({vecs[i].name, "_timeout"}, ok, 32'(ok), 32'h1);
            chk({vecs[i].name, "_latency"}, cyc == 17, 32'(cyc), 32'd17);
            chk({vecs[i].name, "_busycnt"}, bcnt == 16, 32'(bcnt), 32'd16);
            chk({vecs[i].name, "_busy_in_done"}, busy == 1'b0, 32'(busy), 32'h0);
            chk({vecs[i].name, "_result"}, near(res, vecs[i].exp, vecs[i].tol), res, vecs[i].exp);
            @(negedge clk);
            chk({vecs[i].name, "_done_once"}, done == 1'b0, 32'(done), 32'h0);
            chk({vecs[i].name, "_result_hold"}, result == res, result, res);
        end

        // Reset mid-RUN: aborts silently, clears result
        @(negedge clk);
        start = 1'b1; dataa = PI4; n = 2'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy",   busy == 1'b0, 32'(busy), 32'h0);
        chk("midrst_done",   done == 1'b0, 32'(done), 32'h0);
        chk("midrst_result", result == 32'h0, result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy) hits++;
        end
        chk("midrst_no_done", hits == 0, 32'(hits), 32'h0);
        do_op(32'h0, 2'd0, 1000, 0, res, cyc, bcnt, ok);
        chk("after_rst_latency", ok && cyc == 17, 32'(cyc), 32'd17);
        chk("after_rst_result", near(res, 32'h40000000, 32'h8000), res, 32'h40000000);

        // Stall: 3 cycles with clk_en low mid-RUN
        @(negedge clk);
        do_op(PI6, 2'd1, 1000, 0, res_ref, cyc, bcnt, ok);
        chk("ref_sin_pi6", ok && near(res_ref, 32'h20000000, 32'h8000), res_ref, 32'h20000000);
        @(negedge clk);
        sat = int'($urandom_range(2, 12));
        do_op(PI6, 2'd1, sat, 3, res, cyc, bcnt, ok);
        chk("stall_latency", ok && cyc == 20, 32'(cyc), 32'd20);
        chk("stall_busycnt", bcnt == 19, 32'(bcnt), 32'd19);
        chk("stall_identical", res == res_ref, res, res_ref);
        // done held across a clk_en-low edge, then drops on the next enabled edge
        clk_en = 1'b0;
        @(negedge clk);
        chk("stall_done_held", done == 1'b1, 32'(done), 32'h1);
        chk("stall_result_held", result == res_ref, result, res_ref);
        clk_en = 1'b1;
        @(negedge clk);
        chk("stall_done_drop", done == 1'b0, 32'(done), 32'h0);

        // Back-to-back with an ignored mid-RUN start
        @(negedge clk);
        start = 1'b1; dataa = PI6; n = 2'd1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            start = (cyc == 6);
            dataa = (cyc == 6) ? 32'h12345678 : 32'h0;
            n     = (cyc == 6) ? 2'd0 : 2'd1;
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_latency", ok && cyc == 17, 32'(cyc), 32'd17);
        chk("b2b_first_result", near(result, 32'h20000000, 32'h8000), result, 32'h20000000);
        start = 1'b1; dataa = 32'h0; n = 2'd0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy", busy == 1'b1 && done == 1'b0, {30'h0, busy, done}, 32'h2);
        cyc = 1; ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_second_latency", ok && cyc == 17, 32'(cyc), 32'd17);
        chk("b2b_second_result", near(result, 32'h40000000, 32'h8000), result, 32'h40000000);
        @(negedge clk);
        chk("b2b_done_once", done == 1'b0, 32'(done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
